// File: rtl/div_iter.sv
// div_iter: iterative signed 32-bit divider (restoring, one step per clock).
//
// Ports:
//   clock           rising-edge clock for all state
//   reset           asynchronous, active-low reset
//   ctrl_DIV        start request, sampled on the rising edge
//   data_operandA   signed dividend (two's complement)
//   data_operandB   signed divisor (two's complement)
//   data_result     signed quotient, truncated toward zero
//   data_exception  divide-by-zero or 0x80000000 / -1 overflow flag
//   data_resultRDY  one-cycle result-valid pulse
//   data_remainder  signed remainder, sign follows dividend (only with DIV_REMAINDER_EN)
//   busy            high while the shift/subtract iterations run
//
// Build option: define DIV_REMAINDER_EN to add the data_remainder output.
module div_iter (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
`ifdef DIV_REMAINDER_EN
  output logic [31:0] data_remainder,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  count;
  logic [31:0] quo;      // dividend magnitude shifting out, quotient bits shifting in
  logic [31:0] rem;      // partial remainder
  logic [31:0] dvs;      // divisor magnitude
  logic        sign_a;
  logic        sign_b;
  logic        ovf;
  logic        dz_pend;  // divide-by-zero captured; report on the next edge without RUN

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] shl;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] quo_signed;
  logic        ge;
  logic        quo_neg;
`ifdef DIV_REMAINDER_EN
  logic [31:0] rem_signed;
`endif

  always_comb begin
    // Magnitudes are unsigned, so |0x80000000| = 2^31 is exact rather than wrapping.
    a_mag = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    b_mag = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

    // Shifted remainder is logically 33 bits; rem[31] stands in for the carried-out
    // MSB, and when set the subtraction always succeeds and fits in 32 bits.
    shl      = {rem[30:0], quo[31]};
    ge       = rem[31] | (shl >= dvs);
    rem_step = ge ? (shl - dvs) : shl;
    quo_step = {quo[30:0], ge};

    quo_neg    = (sign_a ^ sign_b) & (|quo_step);
    quo_signed = quo_neg ? (~quo_step + 32'd1) : quo_step;
`ifdef DIV_REMAINDER_EN
    rem_signed = (sign_a & (|rem_step)) ? (~rem_step + 32'd1) : rem_step;
`endif
  end

  assign busy = (state == RUN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      quo            <= '0;
      rem            <= '0;
      dvs            <= '0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      ovf            <= 1'b0;
      dz_pend        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (dz_pend) begin
            // Start requests are ignored while a divide-by-zero result is pending.
            dz_pend        <= 1'b0;
            state          <= DONE;
            data_result    <= '0;
            data_exception <= 1'b1;
            data_resultRDY <= 1'b1;
`ifdef DIV_REMAINDER_EN
            data_remainder <= '0;
`endif
          end else if (ctrl_DIV) begin
            quo    <= a_mag;
            rem    <= '0;
            dvs    <= b_mag;
            sign_a <= data_operandA[31];
            sign_b <= data_operandB[31];
            ovf    <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            count  <= '0;
            if (data_operandB == '0) begin
              dz_pend <= 1'b1;
              state   <= IDLE;
            end else begin
              state   <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          quo   <= quo_step;
          rem   <= rem_step;
          count <= count + 6'd1;
          if (count == 6'd31) begin
            state          <= DONE;
            data_result    <= quo_signed;
            data_exception <= ovf;
            data_resultRDY <= 1'b1;
`ifdef DIV_REMAINDER_EN
            data_remainder <= ovf ? '0 : rem_signed;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed-vector bench for div_iter with an arithmetic reference model
// checked every cycle, plus literal expectations for each directed vector.
module tb_div_iter;

  logic        clock    = 1'b0;
  logic        reset    = 1'b1;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] opa      = '0;
  logic [31:0] opb      = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  always #5 clock = ~clock;

  div_iter dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
`ifdef DIV_REMAINDER_EN
    .data_remainder (data_remainder),
`endif
    .busy           (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic with the two exceptional cases.
  task automatic model_of(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic e);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = '0; r = '0; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = '0; e = 1'b1;
    end else begin
      q = 32'(sa / sb); r = 32'(sa % sb); e = 1'b0;
    end
  endtask

  // Model timeline: an accepted request completes a fixed number of edges later.
  int          m_left = 0;
  logic        m_dz   = 1'b0;
  logic        m_rdy  = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_exc  = 1'b0;
  logic        p_exc  = 1'b0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_rem  = '0;
  logic [31:0] p_res  = '0;
  logic [31:0] p_rem  = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_left = 0; m_dz = 1'b0; m_rdy = 1'b0; m_busy = 1'b0;
      m_res = '0; m_rem = '0; m_exc = 1'b0;
    end else begin
      m_rdy = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_res = p_res; m_rem = p_rem; m_exc = p_exc; m_rdy = 1'b1;
        end
      end else if (ctrl_DIV) begin
        model_of(opa, opb, p_res, p_rem, p_exc);
        m_dz   = (opb == '0);
        m_left = m_dz ? 1 : 32;
      end
      m_busy = (m_left > 0) && !m_dz;
    end
  end

  always @(negedge clock) begin
    check("cyc_busy", 32'(busy), 32'(m_busy));
    check("cyc_rdy", 32'(data_resultRDY), 32'(m_rdy));
    check("cyc_result", data_result, m_res);
    check("cyc_exception", 32'(data_exception), 32'(m_exc));
`ifdef DIV_REMAINDER_EN
    check("cyc_remainder", data_remainder, m_rem);
`endif
  end

  // Counts edges until RDY is seen #1 after an edge; -1 if the bound expires.
  task automatic wait_rdy(output int n, input int limit);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_done(input string tag, input int n, input int lat,
                            input logic [31:0] er, input logic ee, input logic [31:0] erem);
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_result"}, data_result, er);
    check({tag, "_exc"}, 32'(data_exception), 32'(ee));
    check({tag, "_model_q"}, p_res, er);
    check({tag, "_model_r"}, p_rem, erem);
`ifdef DIV_REMAINDER_EN
    check({tag, "_rem"}, data_remainder, erem);
`endif
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ee, input logic [31:0] erem,
                         input int lat);
    int n;
    @(posedge clock); #3;
    opa = a; opb = b; ctrl_DIV = 1'b1;
    @(posedge clock); #3;               // capture edge E0 has passed
    ctrl_DIV = 1'b0;
    opa = 32'hDEAD_BEEF; opb = 32'h1234_5678;  // must not disturb the captured operands
    wait_rdy(n, 40);
    check_done(tag, n, lat, er, ee, erem);
  endtask

  initial begin
    int n;
    int seen;
    #2 reset = 1'b0;
    #1;
    check("rst_result", data_result, 32'h0);
    check("rst_rdy", 32'(data_resultRDY), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;

    run_div("d100_7",   32'd100,        32'd7,          32'd14,         1'b0, 32'd2,        32);
    run_div("dm100_7",  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0, 32'hFFFF_FFFE, 32);
    run_div("d100_m7",  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  1'b0, 32'd2,        32);
    run_div("div0",     32'd5,          32'd0,          32'd0,          1'b1, 32'd0,        1);
    run_div("ovf",      32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 32'd0,        32);
    run_div("min_2",    32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0, 32'd0,        32);
    run_div("zero_5",   32'd0,          32'd5,          32'd0,          1'b0, 32'd0,        32);
    run_div("m7_9",     32'hFFFF_FFF9,  32'd9,          32'd0,          1'b0, 32'hFFFF_FFF9, 32);
    run_div("max_1",    32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  1'b0, 32'd0,        32);
    run_div("m1_m1",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,        32);
    run_div("min_min",  32'h8000_0000,  32'h8000_0000,  32'd1,          1'b0, 32'd0,        32);
    run_div("x_min",    32'h1234_5678,  32'h8000_0000,  32'd0,          1'b0, 32'h1234_5678, 32);

    // Back-to-back: start held high through DONE.
    @(posedge clock); #3;
    opa = 32'd9; opb = 32'd3; ctrl_DIV = 1'b1;
    @(posedge clock); #3;
    wait_rdy(n, 40);
    check_done("b2b_1", n, 32, 32'd3, 1'b0, 32'd0);
    opa = 32'hFFFF_FFF7;
    wait_rdy(n, 40);
    ctrl_DIV = 1'b0;
    check_done("b2b_2", n, 33, 32'hFFFF_FFFD, 1'b0, 32'd0);
    repeat (3) @(posedge clock);

    // Reset mid-run, with an ignored start request in flight.
    @(posedge clock); #3;
    opa = 32'd1000; opb = 32'd10; ctrl_DIV = 1'b1;
    @(posedge clock); #3;               // E0
    ctrl_DIV = 1'b0;
    repeat (4) @(posedge clock); #3;    // E4
    opa = 32'd7; opb = 32'd7; ctrl_DIV = 1'b1;
    @(posedge clock); #3;               // E5
    ctrl_DIV = 1'b0;
    repeat (5) @(posedge clock); #2;    // E10
    reset = 1'b0;
    #1;
    check("abort_result", data_result, 32'h0);
    check("abort_exc", 32'(data_exception), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_rdy", 32'(data_resultRDY), 32'h0);
    repeat (2) @(posedge clock); #3;
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (data_resultRDY) seen++;
    end
    check("abort_no_rdy", 32'(seen), 32'h0);

    // Start request already present on the first edge after reset release.
    @(posedge clock); #3;
    reset = 1'b0;
    opa = 32'd1000; opb = 32'd10; ctrl_DIV = 1'b1;
    @(posedge clock); #3;
    reset = 1'b1;
    @(posedge clock); #3;               // E0
    ctrl_DIV = 1'b0;
    wait_rdy(n, 40);
    check_done("restart", n, 32, 32'd100, 1'b0, 32'd0);

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
